// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the fetch-side branch predictor
package bp_pkg;
  localparam int BP_XLEN    = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_XLEN - BP_IDX_W - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    ctr_t                ctr;
  } btb_entry_t;

  // Fresh allocations start weakly taken so one not-taken outcome flips them.
  localparam ctr_t CTR_INIT_TAKEN = WT;
endpackage

// File: rtl/sat_ctr2.sv
// rtl/sat_ctr2.sv - next state of a 2-bit saturating direction counter
module sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);
  always_comb begin
    ctr_next = ctr;
    if (taken && (ctr != ST)) begin
      ctr_next = ctr + 2'd1;
    end else if (!taken && (ctr != SNT)) begin
      ctr_next = ctr - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, registered lookup and redirect
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = BP_XLEN,
  parameter int ENTRIES = BP_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic            if_stall,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     mispredict_cnt
);
  localparam int TAG_W = XLEN - IDX_W - 2;

  btb_entry_t table_q [ENTRIES];
  btb_entry_t table_d [ENTRIES];

  logic            pred_valid_q, pred_valid_d;
  logic            pred_taken_q, pred_taken_d;
  logic [XLEN-1:0] pred_target_q, pred_target_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]     cnt_q, cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  btb_entry_t       if_entry, ex_entry;
  logic             if_hit, if_taken, ex_hit, mispredict;
  logic [1:0]       ctr_upd;

  assign if_idx   = if_pc[IDX_W+1:2];
  assign if_tag   = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx   = ex_pc[IDX_W+1:2];
  assign ex_tag   = ex_pc[XLEN-1:IDX_W+2];
  // Both ports read the registered table, so same-cycle updates are not bypassed.
  assign if_entry = table_q[if_idx];
  assign ex_entry = table_q[ex_idx];
  assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);
  assign if_taken = if_hit && if_entry.ctr[1];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);
  assign mispredict = (ex_taken != ex_pred_taken) ||
                      (ex_taken && (ex_target != ex_pred_target));

  sat_ctr2 u_sat_ctr2 (
    .ctr      (ex_entry.ctr),
    .taken    (ex_taken),
    .ctr_next (ctr_upd)
  );

  always_comb begin
    pred_valid_d  = pred_valid_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (!if_stall) begin
      pred_valid_d = if_valid;
      if (if_valid) begin
        pred_taken_d  = if_taken;
        pred_target_d = if_taken ? if_entry.target : if_pc + XLEN'(4);
      end
    end
  end

  always_comb begin
    redirect_valid_d = ex_valid && mispredict;
    redirect_pc_d    = redirect_pc_q;
    cnt_d            = cnt_q;
    if (ex_valid && mispredict) begin
      redirect_pc_d = ex_taken ? ex_target : ex_pc + XLEN'(4);
      if (cnt_q != 32'hFFFF_FFFF) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    table_d = table_q;
    if (ex_valid) begin
      if (ex_hit) begin
        table_d[ex_idx].ctr = ctr_t'(ctr_upd);
        if (ex_taken) begin
          table_d[ex_idx].target = ex_target;
        end
      end else if (ex_taken) begin
        table_d[ex_idx].valid  = 1'b1;
        table_d[ex_idx].tag    = ex_tag;
        table_d[ex_idx].target = ex_target;
        table_d[ex_idx].ctr    = CTR_INIT_TAKEN;
      end
    end
  end

  // Only the valid bits are reset; tag/target/ctr are don't-care until allocated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
      end
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_target_q    <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      cnt_q            <= '0;
    end else begin
      table_q          <= table_d;
      pred_valid_q     <= pred_valid_d;
      pred_taken_q     <= pred_taken_d;
      pred_target_q    <= pred_target_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      cnt_q            <= cnt_d;
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_taken     = pred_taken_q;
  assign pred_target    = pred_target_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and random checks of branch_predictor against a table model
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0, if_stall = 1'b0;
  logic [31:0] if_pc = '0;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc, mispredict_cnt;

  int total = 0;
  int bad = 0;

  // Reference model: plain arrays indexed by pc[5:2], tag pc[31:6], counter 0..3.
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic        e_pv, e_pt, e_rv;
  logic [31:0] e_ptgt, e_rpc, e_cnt;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_stall(if_stall), .if_pc(if_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    e_pv = 0; e_pt = 0; e_ptgt = '0; e_rv = 0; e_rpc = '0; e_cnt = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pred_valid"}, {31'd0, pred_valid}, {31'd0, e_pv});
    chk({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, e_pt});
    chk({tag, ".pred_target"}, pred_target, e_ptgt);
    chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, e_rv});
    chk({tag, ".redirect_pc"}, redirect_pc, e_rpc);
    chk({tag, ".mispredict_cnt"}, mispredict_cnt, e_cnt);
  endtask

  task automatic step(input string tag, input logic iv, input logic ist, input logic [31:0] ipc,
                      input logic ev, input logic [31:0] epc, input logic et,
                      input logic [31:0] etgt, input logic ept, input logic [31:0] eptgt);
    int  i;
    logic hit, mis;
    if_valid = iv; if_stall = ist; if_pc = ipc;
    ex_valid = ev; ex_pc = epc; ex_taken = et; ex_target = etgt;
    ex_pred_taken = ept; ex_pred_target = eptgt;
    if (!ist) begin
      e_pv = iv;
      if (iv) begin
        i = int'(ipc[5:2]);
        hit = m_valid[i] && (m_tag[i] == ipc[31:6]);
        e_pt = hit && (m_ctr[i] >= 2);
        e_ptgt = e_pt ? m_tgt[i] : ipc + 32'd4;
      end
    end
    mis = ev && ((et != ept) || (et && (etgt != eptgt)));
    e_rv = mis;
    if (mis) begin
      e_rpc = et ? etgt : epc + 32'd4;
      if (e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 32'd1;
    end
    if (ev) begin
      i = int'(epc[5:2]);
      hit = m_valid[i] && (m_tag[i] == epc[31:6]);
      if (hit) begin
        m_ctr[i] = et ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (et) m_tgt[i] = etgt;
      end else if (et) begin
        m_valid[i] = 1'b1; m_tag[i] = epc[31:6]; m_tgt[i] = etgt; m_ctr[i] = 2;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc);
    step(tag, 1, 0, pc, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic train(input string tag, input logic [31:0] pc, input logic t,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    step(tag, 0, 0, '0, 1, pc, t, tgt, pt, ptgt);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] pcs [8];
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    lookup("cold", 32'h100);
    chk("cold.taken_const", {31'd0, pred_taken}, 32'd0);
    chk("cold.target_const", pred_target, 32'h104);

    train("alloc", 32'h100, 1, 32'h40, 0, 32'h0);
    chk("alloc.rpc_const", redirect_pc, 32'h40);
    chk("alloc.cnt_const", mispredict_cnt, 32'd1);
    lookup("alloc.look", 32'h100);
    chk("alloc.target_const", pred_target, 32'h40);

    for (int k = 0; k < 3; k++) train("sat.t", 32'h100, 1, 32'h40, 1, 32'h40);
    lookup("sat.look0", 32'h100);
    for (int k = 0; k < 3; k++) begin
      train("sat.nt", 32'h100, 0, 32'h40, 1, 32'h40);
      lookup("sat.look", 32'h100);
    end
    chk("sat.final_target_const", pred_target, 32'h104);

    train("wrap", 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h8);
    chk("wrap.rpc_const", redirect_pc, 32'h0);

    train("rst.pre", 32'h200, 1, 32'h20, 0, 32'h0);
    do_reset("rst.mid_redirect");

    step("same", 1, 0, 32'h100, 1, 32'h100, 1, 32'h40, 0, 32'h0);
    chk("same.taken_const", {31'd0, pred_taken}, 32'd0);
    lookup("same.next", 32'h100);
    chk("same.next_taken_const", {31'd0, pred_taken}, 32'd1);

    train("alias", 32'h500, 1, 32'h80, 0, 32'h0);
    lookup("alias.old", 32'h100);
    chk("alias.old_target_const", pred_target, 32'h104);
    lookup("alias.new", 32'h500);
    chk("alias.new_target_const", pred_target, 32'h80);

    step("stall1", 1, 1, 32'h100, 0, '0, 0, '0, 0, '0);
    step("stall2", 1, 1, 32'h104, 1, 32'h104, 1, 32'h90, 0, '0);
    step("stall3", 1, 1, 32'h108, 0, '0, 0, '0, 0, '0);
    chk("stall.target_const", pred_target, 32'h80);
    lookup("stall.after", 32'h104);

    for (int k = 0; k < 8; k++) pcs[k] = {24'($urandom_range(0, 2)), 6'd0, 2'd0} | (32'($urandom_range(0, 3)) << 2);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ipc, epc, etgt, eptgt;
      logic et, ept;
      ipc   = pcs[$urandom_range(0, 7)];
      epc   = pcs[$urandom_range(0, 7)];
      et    = 1'($urandom);
      ept   = 1'($urandom);
      etgt  = 32'($urandom_range(0, 15)) << 4;
      eptgt = ($urandom_range(0, 3) == 0) ? etgt + 32'h10 : etgt;
      step("rand", 1'($urandom), ($urandom_range(0, 3) == 0), ipc,
           1'($urandom), epc, et, etgt, ept, eptgt);
      if (n == 200) do_reset("rand.reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
